// File: rtl/tx_pkg.sv
// Shared constants and helpers for the TX interpolator: rate encoding,
// per-rate tick period and output scaling shift.
package tx_pkg;

    localparam logic [1:0] RATE_48K  = 2'b00;
    localparam logic [1:0] RATE_96K  = 2'b01;
    localparam logic [1:0] RATE_192K = 2'b10;

    localparam int BASE_PERIOD   = 2560;
    // Bit growth of a 3-stage CIC at the largest ratio: ceil(2*log2(2560))
    localparam int CIC_GROWTH    = 23;
    localparam int DEF_IN_WIDTH  = 16;
    localparam int DEF_OUT_WIDTH = 22;
    localparam int DEF_ACC_WIDTH = DEF_IN_WIDTH + CIC_GROWTH;

    // Encoding 11 is an alias of the 192 kHz setting.
    function automatic logic [1:0] norm_rate(input logic [1:0] r);
        return (r == 2'b11) ? RATE_192K : r;
    endfunction

    function automatic int period(input logic [1:0] r);
        return BASE_PERIOD >> norm_rate(r);
    endfunction

    function automatic int shift(input logic [1:0] r, input int in_w, input int out_w);
        return in_w + CIC_GROWTH - out_w - 2 * int'(norm_rate(r));
    endfunction

endpackage

// File: rtl/cic_interp_core.sv
// One channel of the CIC interpolator: combs at the sample rate, zero-stuffing,
// integrators at the clock rate and a rate-dependent output shift.
module cic_interp_core
    import tx_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int ACC_WIDTH = IN_WIDTH + CIC_GROWTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        tick,
    input  logic [1:0]                  rate_r,
    input  logic signed [IN_WIDTH-1:0]  sample,
    output logic signed [OUT_WIDTH-1:0] out_data
);

    logic signed [ACC_WIDTH-1:0]  sample_ext;
    logic signed [ACC_WIDTH-1:0]  up_reg;
    logic signed [OUT_WIDTH-1:0]  out_reg;
    logic [5:0]                   shift_amt;

    assign sample_ext = {{(ACC_WIDTH-IN_WIDTH){sample[IN_WIDTH-1]}}, sample};
    assign shift_amt  = 6'(shift(rate_r, IN_WIDTH, OUT_WIDTH));

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_comb
            logic signed [ACC_WIDTH-1:0] diff_in;
            logic signed [ACC_WIDTH-1:0] diff_out;
            logic signed [ACC_WIDTH-1:0] dly_reg;

            if (gi == 0) begin : g_first
                assign diff_in = sample_ext;
            end else begin : g_next
                assign diff_in = g_comb[gi-1].diff_out;
            end

            assign diff_out = diff_in - dly_reg;

            // Comb delays advance only at the low (sample) rate.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    dly_reg <= '0;
                end else if (clear) begin
                    dly_reg <= '0;
                end else if (tick) begin
                    dly_reg <= diff_in;
                end
            end
        end
    endgenerate

    // Zero-stuffing: the comb result is injected only on the tick cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            up_reg <= '0;
        end else if (clear) begin
            up_reg <= '0;
        end else begin
            up_reg <= tick ? g_comb[STAGES-1].diff_out : '0;
        end
    end

    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_integ
            logic signed [ACC_WIDTH-1:0] acc_in;
            logic signed [ACC_WIDTH-1:0] acc_reg;

            if (gi == 0) begin : g_first
                assign acc_in = up_reg;
            end else begin : g_next
                assign acc_in = g_integ[gi-1].acc_reg;
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    acc_reg <= '0;
                end else if (clear) begin
                    acc_reg <= '0;
                end else begin
                    acc_reg <= acc_reg + acc_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_reg <= '0;
        end else if (clear) begin
            out_reg <= '0;
        end else begin
            out_reg <= OUT_WIDTH'(g_integ[STAGES-1].acc_reg >>> shift_amt);
        end
    end

    assign out_data = out_reg;

endmodule

// File: rtl/tx_interp.sv
// TX baseband upsampler: pulls I/Q samples from the host FIFO once per period
// and interpolates them to the system clock through two CIC channels.
module tx_interp
    import tx_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int ACC_WIDTH = IN_WIDTH + CIC_GROWTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  rate,
    output logic                        in_req,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  in_data_I,
    input  logic signed [IN_WIDTH-1:0]  in_data_Q,
    output logic signed [OUT_WIDTH-1:0] out_data_I,
    output logic signed [OUT_WIDTH-1:0] out_data_Q,
    output logic                        underrun,
    output logic                        overrun
);

    localparam int CNT_W = 12;

    logic [1:0]                 rate_r;
    logic [1:0]                 rate_n;
    logic                       rate_chg;
    logic                       tick;
    logic [CNT_W-1:0]           count_reg;
    logic                       held_reg;
    logic signed [IN_WIDTH-1:0] hold_i_reg;
    logic signed [IN_WIDTH-1:0] hold_q_reg;
    logic signed [IN_WIDTH-1:0] cons_i;
    logic signed [IN_WIDTH-1:0] cons_q;

    assign rate_n   = norm_rate(rate);
    assign rate_chg = (rate_n != rate_r);
    // A rate change suppresses the tick; the reloaded counter fires one clock later.
    assign tick     = !reset && !rate_chg && (count_reg == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rate_r    <= RATE_48K;
            count_reg <= '0;
        end else if (rate_chg) begin
            rate_r    <= rate_n;
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= CNT_W'(period(rate_r) - 1);
        end else begin
            count_reg <= count_reg - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held_reg   <= 1'b0;
            hold_i_reg <= '0;
            hold_q_reg <= '0;
        end else if (rate_chg) begin
            held_reg   <= 1'b0;
            hold_i_reg <= '0;
            hold_q_reg <= '0;
        end else if (tick) begin
            held_reg   <= 1'b0;
        end else if (in_valid) begin
            held_reg   <= 1'b1;
            hold_i_reg <= in_data_I;
            hold_q_reg <= in_data_Q;
        end
    end

    // Live input beats the held copy; with neither, silence is injected.
    always_comb begin
        cons_i = '0;
        cons_q = '0;
        if (in_valid) begin
            cons_i = in_data_I;
            cons_q = in_data_Q;
        end else if (held_reg) begin
            cons_i = hold_i_reg;
            cons_q = hold_q_reg;
        end
    end

    assign in_req   = tick;
    assign underrun = tick && !in_valid && !held_reg;
    assign overrun  = !tick && !rate_chg && in_valid && held_reg;

    cic_interp_core #(
        .STAGES    (STAGES),
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_core_i (
        .clock    (clock),
        .reset    (reset),
        .clear    (rate_chg),
        .tick     (tick),
        .rate_r   (rate_r),
        .sample   (cons_i),
        .out_data (out_data_I)
    );

    cic_interp_core #(
        .STAGES    (STAGES),
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_core_q (
        .clock    (clock),
        .reset    (reset),
        .clear    (rate_chg),
        .tick     (tick),
        .rate_r   (rate_r),
        .sample   (cons_q),
        .out_data (out_data_Q)
    );

endmodule

// File: tb/tb_tx_interp.sv
// Self-checking bench for tx_interp: a sample-level CIC reference model compared
// every cycle, plus directed literal expectations for the key scenarios.
module tb_tx_interp;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [1:0]         rate = 2'd0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_data_I = '0;
    logic signed [15:0] in_data_Q = '0;
    logic               in_req;
    logic signed [21:0] out_data_I;
    logic signed [21:0] out_data_Q;
    logic               underrun;
    logic               overrun;

    always #4 clock = ~clock;

    tx_interp dut (
        .clock      (clock),
        .reset      (reset),
        .rate       (rate),
        .in_req     (in_req),
        .in_valid   (in_valid),
        .in_data_I  (in_data_I),
        .in_data_Q  (in_data_Q),
        .out_data_I (out_data_I),
        .out_data_Q (out_data_Q),
        .underrun   (underrun),
        .overrun    (overrun)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int PER_TAB[3]   = '{2560, 1280, 640};
    int SHIFT_TAB[3] = '{17, 15, 13};

    logic [1:0]         m_rate;
    int                 next_tick;
    logic               m_held;
    longint             hold_i, hold_q;
    longint             h_i[4], h_q[4];
    logic signed [38:0] s1_i, s2_i, s3_i, s1_q, s2_q, s3_q, t_i, t_q;
    logic signed [21:0] q_i[$], q_q[$];
    logic [1:0]         rn;
    logic               chg, tk, e_req, e_under, e_over;
    logic signed [21:0] e_i, e_q;
    longint             x_i, x_q, v_i, v_q;

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            h_i[k] = 0;
            h_q[k] = 0;
        end
        s1_i = '0; s2_i = '0; s3_i = '0;
        s1_q = '0; s2_q = '0; s3_q = '0;
        m_held = 1'b0;
        hold_i = 0;
        hold_q = 0;
        q_i.delete();
        q_q.delete();
        repeat (5) begin
            q_i.push_back('0);
            q_q.push_back('0);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            e_req = 0; e_under = 0; e_over = 0; e_i = '0; e_q = '0;
            model_clear();
            m_rate = 2'd0;
            next_tick = cyc + 1;
        end else begin
            rn  = (rate == 2'd3) ? 2'd2 : rate;
            chg = (rn != m_rate);
            tk  = !chg && (cyc == next_tick);
            e_req   = tk;
            e_under = tk && !in_valid && !m_held;
            e_over  = !tk && !chg && in_valid && m_held;
            e_i = q_i[0];
            e_q = q_q[0];
            if (chg) begin
                model_clear();
                m_rate = rn;
                next_tick = cyc + 1;
            end else begin
                v_i = 0;
                v_q = 0;
                if (tk) begin
                    x_i = in_valid ? longint'(in_data_I) : (m_held ? hold_i : 0);
                    x_q = in_valid ? longint'(in_data_Q) : (m_held ? hold_q : 0);
                    for (int k = 3; k > 0; k--) begin
                        h_i[k] = h_i[k-1];
                        h_q[k] = h_q[k-1];
                    end
                    h_i[0] = x_i;
                    h_q[0] = x_q;
                    // Third difference of the consumed sample sequence
                    v_i = h_i[0] - 3 * h_i[1] + 3 * h_i[2] - h_i[3];
                    v_q = h_q[0] - 3 * h_q[1] + 3 * h_q[2] - h_q[3];
                    m_held = 1'b0;
                    next_tick = cyc + PER_TAB[m_rate];
                end else if (in_valid) begin
                    hold_i = longint'(in_data_I);
                    hold_q = longint'(in_data_Q);
                    m_held = 1'b1;
                end
                s1_i = s1_i + 39'(v_i); s2_i = s2_i + s1_i; s3_i = s3_i + s2_i;
                s1_q = s1_q + 39'(v_q); s2_q = s2_q + s1_q; s3_q = s3_q + s2_q;
                t_i = s3_i >>> SHIFT_TAB[m_rate];
                t_q = s3_q >>> SHIFT_TAB[m_rate];
                void'(q_i.pop_front());
                void'(q_q.pop_front());
                q_i.push_back(t_i[21:0]);
                q_q.push_back(t_q[21:0]);
            end
        end
        check("in_req",   longint'(in_req),   longint'(e_req));
        check("underrun", longint'(underrun), longint'(e_under));
        check("overrun",  longint'(overrun),  longint'(e_over));
        check("out_I",    longint'(out_data_I), longint'(e_i));
        check("out_Q",    longint'(out_data_Q), longint'(e_q));
        cyc++;
    end

    // ---------------- driver ----------------
    int                 tb_cyc = 0;
    int                 resp_cnt = -1;
    bit                 auto_on = 0;
    bit                 rand_mode = 0;
    bit                 skip_next = 0;
    logic signed [15:0] src_i = '0, src_q = '0;
    logic [1:0]         rate_cmd = 2'd0;
    logic               reset_cmd = 1'b1;
    int                 last_req = 0, req_gap = 0, n_req = 0, n_under = 0, n_over = 0;

    task automatic drive_cycle(input bit fv, input logic signed [15:0] fi, input logic signed [15:0] fq);
        @(posedge clock);
        #1;
        reset    = reset_cmd;
        rate     = rate_cmd;
        in_valid = 1'b0;
        if (auto_on && resp_cnt == 0) begin
            in_valid = 1'b1;
            if (rand_mode) begin
                in_data_I = 16'($urandom);
                in_data_Q = 16'($urandom);
            end else begin
                in_data_I = src_i;
                in_data_Q = src_q;
            end
        end
        if (resp_cnt >= 0) resp_cnt--;
        if (fv) begin
            in_valid  = 1'b1;
            in_data_I = fi;
            in_data_Q = fq;
        end
        @(negedge clock);
        if (in_req) begin
            req_gap  = tb_cyc - last_req;
            last_req = tb_cyc;
            n_req++;
            if (auto_on) begin
                if (skip_next || (rand_mode && $urandom_range(0, 7) == 0))
                    skip_next = 0;
                else
                    resp_cnt = rand_mode ? int'($urandom_range(0, 29)) : 4;
            end
        end
        if (underrun) n_under++;
        if (overrun)  n_over++;
        tb_cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) drive_cycle(1'b0, '0, '0);
    endtask

    // Rate change cycle followed by a tick cycle that gets a preloaded sample.
    task automatic change_rate(input logic [1:0] r);
        resp_cnt = -1;
        rate_cmd = r;
        drive_cycle(1'b0, '0, '0);
        drive_cycle(1'b1, src_i, src_q);
    endtask

    task automatic wait_req(input int bound);
        int start;
        start = n_req;
        for (int k = 0; k < bound && n_req == start; k++) drive_cycle(1'b0, '0, '0);
        check("req_wait", n_req - start, 1);
    endtask

    int     rel, c0, nz, t2;
    longint peak;

    initial begin
        run(4);

        // Scenario 1: 48 kHz, constant +/-16384, answered 5 clocks after each request
        src_i = 16'sd16384;
        src_q = -16'sd16384;
        auto_on = 1;
        reset_cmd = 0;
        n_under = 0; n_over = 0;
        drive_cycle(1'b1, src_i, src_q);
        run(6 * 2560);
        check("gap_48k", req_gap, 2560);
        check("ss_I_48k", longint'(out_data_I), 819200);
        check("ss_Q_48k", longint'(out_data_Q), -819200);
        check("under_48k", n_under, 0);
        check("over_48k", n_over, 0);

        // Scenario 2: 96 kHz and 192 kHz
        change_rate(2'd1);
        run(6 * 1280);
        check("gap_96k", req_gap, 1280);
        check("ss_I_96k", longint'(out_data_I), 819200);
        check("ss_Q_96k", longint'(out_data_Q), -819200);
        change_rate(2'd2);
        run(6 * 640);
        check("gap_192k", req_gap, 640);
        check("ss_I_192k", longint'(out_data_I), 819200);
        check("ss_Q_192k", longint'(out_data_Q), -819200);

        // Mid-stream 48k -> 192k change: tick on the very next clock
        change_rate(2'd0);
        run(1000);
        c0 = tb_cyc;
        change_rate(2'd2);
        check("chg_next_tick", last_req, c0 + 1);
        run(3 * 640 + 5);
        check("gap_after_chg", req_gap, 640);

        // Underrun: one request left unanswered
        n_under = 0;
        skip_next = 1;
        run(3 * 640);
        check("underrun_once", n_under, 1);

        // Overrun: 100 then 200 between ticks, then a tick-coincident sample
        auto_on = 0;
        resp_cnt = -1;
        wait_req(700);
        n_under = 0; n_over = 0;
        drive_cycle(1'b1, 16'sd100, 16'sd100);
        run(10);
        drive_cycle(1'b1, 16'sd200, 16'sd200);
        check("overrun_once", n_over, 1);
        wait_req(700);
        check("held_consumed_no_under", n_under, 0);
        t2 = last_req + 640;
        run(t2 - tb_cyc);
        drive_cycle(1'b1, 16'sd300, -16'sd300);
        check("coincident_tick", last_req, t2);
        check("coincident_no_over", n_over, 1);
        check("coincident_no_under", n_under, 0);

        // Reset mid-period, release at 192k, then a single impulse
        run(200);
        src_i = '0;
        src_q = '0;
        auto_on = 1;
        resp_cnt = -1;
        reset_cmd = 1;
        run(3);
        resp_cnt = -1;
        reset_cmd = 0;
        rel = tb_cyc;
        drive_cycle(1'b0, '0, '0);
        drive_cycle(1'b1, 16'sd32767, '0);
        check("reset_next_tick", last_req - rel, 1);
        nz = 0;
        peak = 0;
        for (int k = 0; k < 3000; k++) begin
            drive_cycle(1'b0, '0, '0);
            if (out_data_I != 0) nz++;
            if (longint'(out_data_I) > peak) peak = longint'(out_data_I);
        end
        check("impulse_len", nz, 3 * 640 - 2);
        check("impulse_peak", peak, 1228762);

        // Encoding 11 aliases 192k: no rate change, spacing unchanged
        rate_cmd = 2'd3;
        run(3 * 640);
        check("gap_rate11", req_gap, 640);

        // Randomized traffic: data, delays, skips, extra pushes, rate changes, resets
        rand_mode = 1;
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 1999) == 0) rate_cmd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4999) == 0) begin
                reset_cmd = 1;
                run(int'($urandom_range(1, 3)));
                reset_cmd = 0;
            end
            drive_cycle($urandom_range(0, 299) == 0, 16'($urandom), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
